// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I core front end.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order queue of fetched {pc, instr} entries between the fetch logic and
// decode. Head is read combinationally so a pushed entry is visible the cycle
// after it is written; flush empties the queue in one cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign count = count_reg;
    assign head  = empty ? '0 : mem_reg[rd_ptr_reg];

    // The fetch credit scheme must never let a response arrive into a full queue.
    overflow_check: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: issues fixed-latency fetch requests, captures
// responses into an in-order queue and presents {pc, instr} to decode. A
// redirect flushes everything in flight and restarts fetch at the new target.
module fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);
    import cpu_pkg::*;

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] fetch_pc_next;
    logic            resp_pending_reg;
    logic            resp_pending_next;
    logic [XLEN-1:0] resp_pc_reg;
    logic [XLEN-1:0] resp_pc_next;
    logic [CW-1:0]   q_count;
    logic [CW:0]     in_flight;
    logic            credit_ok;
    logic            q_push;
    logic            q_pop;
    fetch_entry_t    q_push_data;
    fetch_entry_t    q_head;

    // Entries already queued plus the one response still on its way; no
    // credit is taken back for a pop happening in the same cycle.
    assign in_flight = {1'b0, q_count} + {{CW{1'b0}}, resp_pending_reg};
    assign credit_ok = (in_flight < (CW+1)'(QUEUE_DEPTH));

    assign imem_req  = !rst && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc_reg;

    // Next PC / response tracking: redirect overrides sequential fetch.
    always_comb begin
        fetch_pc_next     = fetch_pc_reg;
        resp_pending_next = 1'b0;
        resp_pc_next      = resp_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
        end else if (imem_req) begin
            fetch_pc_next     = fetch_pc_reg + XLEN'(4);
            resp_pending_next = 1'b1;
            resp_pc_next      = fetch_pc_reg;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg     <= RESET_PC;
            resp_pending_reg <= 1'b0;
            resp_pc_reg      <= '0;
        end else begin
            fetch_pc_reg     <= fetch_pc_next;
            resp_pending_reg <= resp_pending_next;
            resp_pc_reg      <= resp_pc_next;
        end
    end

    // A response arriving during a redirect belongs to the old stream and is dropped.
    assign q_push            = resp_pending_reg && !redirect_valid;
    assign q_push_data.pc    = resp_pc_reg;
    assign q_push_data.instr = imem_rdata;
    assign q_pop             = out_valid && out_ready;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head      (q_head)
    );

    assign out_valid = (q_count != '0) && !redirect_valid;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;

endmodule
